// File: rtl/sa_result_drain.sv
// Result drain for the 8x8 systolic array. It snapshots every PE accumulator on
// the rising edge of compute_done, then streams the words out in row-major order.
// Define SA_DRAIN_RELU_EN to clamp negative output words to zero.
module sa_result_drain #(
  parameter int NUM_ROW       = 8,
  parameter int NUM_COL       = 8,
  parameter int OUT_WORD_SIZE = 24
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      compute_done,
  input  logic [NUM_ROW*NUM_COL*OUT_WORD_SIZE-1:0]  pe_register_vals,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [OUT_WORD_SIZE-1:0]                  out_data,
  output logic [$clog2(NUM_ROW)-1:0]                out_row,
  output logic [$clog2(NUM_COL)-1:0]                out_col,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      drain_done,
  output logic                                      overrun
);

  localparam int NUM_PE = NUM_ROW * NUM_COL;
  localparam int IDX_W  = $clog2(NUM_PE);
  localparam int ROW_W  = $clog2(NUM_ROW);
  localparam int COL_W  = $clog2(NUM_COL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
  localparam logic [IDX_W-1:0] NCOL     = IDX_W'(NUM_COL);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                   state;
  logic [IDX_W-1:0]         index;
  logic                     compute_done_q;
  logic [OUT_WORD_SIZE-1:0] bank [NUM_PE];
  logic                     start;
  logic [OUT_WORD_SIZE-1:0] word;
  logic [IDX_W-1:0]         row_full;
  logic [IDX_W-1:0]         col_full;

  always_comb start = compute_done & ~compute_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      index          <= '0;
      compute_done_q <= 1'b0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      drain_done     <= 1'b0;
      overrun        <= 1'b0;
      for (int unsigned k = 0; k < NUM_PE; k++) bank[k] <= '0;
    end else begin
      compute_done_q <= compute_done;
      drain_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // PE 0 occupies the most significant slice of the flattened bus
            for (int unsigned k = 0; k < NUM_PE; k++)
              bank[k] <= pe_register_vals[(NUM_PE-k)*OUT_WORD_SIZE-1 -: OUT_WORD_SIZE];
            index     <= '0;
            state     <= STREAM;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        STREAM: begin
          if (start) overrun <= 1'b1;
          if (out_ready) begin
            if (index == LAST_IDX) begin
              state      <= IDLE;
              index      <= '0;
              out_valid  <= 1'b0;
              busy       <= 1'b0;
              drain_done <= 1'b1;
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    word     = bank[index];
    row_full = index / NCOL;
    col_full = index % NCOL;
    out_row  = row_full[ROW_W-1:0];
    out_col  = col_full[COL_W-1:0];
    out_last = out_valid & (index == LAST_IDX);
`ifdef SA_DRAIN_RELU_EN
    out_data = word[OUT_WORD_SIZE-1] ? '0 : word;
`else
    out_data = word;
`endif
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Scoreboard bench for sa_result_drain: stimulus queues expected words, and a
// negedge monitor checks each accepted transfer and the drain_done pulse.
module tb_sa_result_drain;
  localparam int NR = 8, NC = 8, W = 24, N = NR * NC;

  logic           clk = 1'b0;
  logic           rst;
  logic           compute_done;
  logic [N*W-1:0] pe_register_vals;
  logic           out_valid, out_ready, out_last, busy, drain_done, overrun;
  logic [W-1:0]   out_data;
  logic [2:0]     out_row, out_col;

  sa_result_drain #(.NUM_ROW(NR), .NUM_COL(NC), .OUT_WORD_SIZE(W)) dut (
    .clk(clk), .rst(rst), .compute_done(compute_done),
    .pe_register_vals(pe_register_vals), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_last(out_last), .busy(busy),
    .drain_done(drain_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [2:0]   r;
    logic [2:0]   c;
    logic         l;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] pe[N];
  int           checks = 0, errors = 0;
  int           cyc = 0, xfer_cnt = 0, first_cyc = -1, last_cyc = 0;
  logic         pending_dd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef SA_DRAIN_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic load_pe();
    for (int k = 0; k < N; k++) pe_register_vals[(N-k)*W-1 -: W] = pe[k];
  endtask

  task automatic push_all();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.d = relu(pe[k]);
      e.r = 3'(k / NC);
      e.c = 3'(k % NC);
      e.l = (k == N - 1);
      q.push_back(e);
    end
  endtask

  // Monitor: a transfer is committed at the next posedge when valid & ready here.
  always @(negedge clk) begin
    if (rst) begin
      pending_dd = 1'b0;
    end else begin
      chk("drain_done", {31'b0, drain_done}, {31'b0, pending_dd});
      pending_dd = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 32'(out_data), 32'hDEAD);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_row", 32'(out_row), 32'(e.r));
          chk("out_col", 32'(out_col), 32'(e.c));
          chk("out_last", 32'(out_last), 32'(e.l));
          if (e.l) pending_dd = 1'b1;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          xfer_cnt++;
        end
      end
    end
  end

  // mode 0: ready held high; mode 1: ready pattern 1,0,0 and the PE inputs are
  // overwritten with all ones part-way through the drain.
  task automatic wait_drain(input int mode);
    int n;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      out_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      if (mode == 1 && n == 10) pe_register_vals = '1;
      n++;
      if (q.size() == 0 && !out_valid) break;
      if (n > 2000) begin
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
        break;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; compute_done = 1'b0; out_ready = 1'b0; pe_register_vals = '0;
    tick(3);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Basic drain of k+1 with ready high, with latency and throughput checks
    for (int k = 0; k < N; k++) pe[k] = W'(k + 1);
    load_pe();
    out_ready = 1'b1;
    push_all();
    first_cyc = -1;
    compute_done = 1'b1;
    @(negedge clk);
    chk("pre_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_busy", {31'b0, busy}, 32'd1);
    wait_drain(0);
    chk("throughput", 32'(last_cyc - first_cyc), 32'd63);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("no_overrun", {31'b0, overrun}, 32'd0);
    compute_done = 1'b0;
    tick(3);

    // Backpressure with the PE inputs trashed mid-drain
    load_pe();
    push_all();
    compute_done = 1'b1;
    wait_drain(1);
    compute_done = 1'b0;
    chk("bp_overrun", {31'b0, overrun}, 32'd0);
    tick(3);

    // Re-raised compute_done during the drain is ignored and flags overrun
    load_pe();
    out_ready = 1'b1;
    push_all();
    base = xfer_cnt;
    compute_done = 1'b1;
    tick(3);
    compute_done = 1'b0;
    while (xfer_cnt - base < 10) tick(1);
    compute_done = 1'b1;
    wait_drain(0);
    chk("overrun_set", {31'b0, overrun}, 32'd1);
    compute_done = 1'b0;
    tick(4);
    chk("overrun_sticky", {31'b0, overrun}, 32'd1);

    // Reset at word 20, then compute_done already high at release restarts from (0,0)
    push_all();
    base = xfer_cnt;
    compute_done = 1'b1;
    while (xfer_cnt - base < 20) tick(1);
    rst = 1'b1;
    tick(1);
    q.delete();
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_overrun", {31'b0, overrun}, 32'd0);
    push_all();
    rst = 1'b0;
    wait_drain(0);
    compute_done = 1'b0;
    tick(3);

    // Sign handling: PE 5 negative, PE 6 max positive
    pe[5] = 24'h800001;
    pe[6] = 24'h7FFFFF;
    load_pe();
    push_all();
    compute_done = 1'b1;
    wait_drain(0);
    compute_done = 1'b0;
    tick(3);
    chk("final_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
